// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - counter type, reset PC and branch-offset helper shared by the npc_bht files
package npc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_bht_table.sv
// rtl/npc_bht_table.sv - 2-bit saturating counter array, read on F_PC, update from E
// Built only when NPC_BHT_EN is defined.
`ifdef NPC_BHT_EN
module npc_bht_table
  import npc_pkg::*;
#(
  parameter int   DEPTH    = 64,
  parameter int   IDX_W    = $clog2(DEPTH),
  parameter cnt_t CNT_INIT = WNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output cnt_t             rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  cnt_t       cnt_q [DEPTH];
  logic [1:0] upd_cur;
  logic [1:0] upd_cnt_d;

  // Read is the registered value, so a same-cycle update to this index is not seen.
  assign rd_cnt_o = cnt_q[rd_idx_i];
  assign upd_cur  = cnt_q[upd_idx_i];

  always_comb begin
    upd_cnt_d = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != 2'b11) upd_cnt_d = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_cnt_d = upd_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= cnt_t'(upd_cnt_d);
    end
  end

endmodule
`endif

// File: rtl/npc_bht.sv
// rtl/npc_bht.sv - F-stage next-PC unit with delay slots, BHT prediction and E-stage repair
// NPC_BHT_EN selects the counter table; otherwise static backward-taken/forward-not-taken.
module npc_bht
  import npc_pkg::*;
#(
  parameter int          BHT_DEPTH = 64,
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter cnt_t        CNT_INIT  = WNT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        F_is_br,
  input  logic        F_is_jal,
  input  logic [25:0] F_Imm26,
  input  logic        D_jr,
  input  logic [31:0] D_jr_target,
  input  logic        E_br,
  input  logic [31:0] E_PC,
  input  logic        E_taken,
  input  logic        E_pred,
  input  logic [31:0] E_target,
  output logic [31:0] F_PC,
  output logic        F_pred,
  output logic        flush_F
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [31:0] f_pc_q, f_pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        redir_v_q, redir_v_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        mis;
  logic        pred;
  logic [31:0] fix_pc, seq_pc, btgt, jtgt;

  assign mis    = E_br & (E_taken != E_pred);
  assign fix_pc = E_taken ? E_target : E_PC + 32'd8;
  assign seq_pc = f_pc_q + 32'd4;
  assign btgt   = seq_pc + br_offset(F_Imm26[15:0]);
  assign jtgt   = {f_pc_q[31:28], F_Imm26, 2'b00};

`ifdef NPC_BHT_EN
  cnt_t rd_cnt;

  npc_bht_table #(
    .DEPTH    (BHT_DEPTH),
    .IDX_W    (IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (f_pc_q[IDX_W+1:2]),
    .rd_cnt_o    (rd_cnt),
    .upd_en_i    (E_br),
    .upd_idx_i   (E_PC[IDX_W+1:2]),
    .upd_taken_i (E_taken)
  );

  assign pred = F_is_br & rd_cnt[1];
`else
  logic unused_cfg;
  assign unused_cfg = ^{2'(CNT_INIT), 8'(IDX_W)};
  assign pred       = F_is_br & F_Imm26[15];
`endif

  assign F_PC    = f_pc_q;
  assign F_pred  = pred;
  // A buffered redirect flushes again once the frozen F/D register can take it.
  assign flush_F = mis | (redir_v_q & ~stall);

  always_comb begin
    f_pc_d     = f_pc_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    redir_v_d  = redir_v_q;
    redir_pc_d = redir_pc_q;
    if (mis) begin
      pend_v_d = 1'b0;
      if (stall) begin
        redir_v_d  = 1'b1;
        redir_pc_d = fix_pc;
      end else begin
        f_pc_d    = fix_pc;
        redir_v_d = 1'b0;
      end
    end else if (redir_v_q && !stall) begin
      f_pc_d    = redir_pc_q;
      redir_v_d = 1'b0;
    end else if (!stall) begin
      if (D_jr) begin
        f_pc_d = D_jr_target;
      end else if (pend_v_q) begin
        f_pc_d   = pend_pc_q;
        pend_v_d = 1'b0;
      end else if (F_is_br || F_is_jal) begin
        // Fetch the delay slot first; the control-flow target follows next cycle.
        f_pc_d    = seq_pc;
        pend_v_d  = 1'b1;
        pend_pc_d = F_is_jal ? jtgt : (pred ? btgt : f_pc_q + 32'd8);
      end else begin
        f_pc_d = seq_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q     <= PC_RESET;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= 32'd0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= 32'd0;
    end else begin
      f_pc_q     <= f_pc_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_npc_bht.sv
// tb/tb_npc_bht.sv - directed self-checking bench for npc_bht (either NPC_BHT_EN setting)
module tb_npc_bht;

`ifdef NPC_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, F_is_br, F_is_jal, D_jr, E_br, E_taken, E_pred;
  logic [25:0] F_Imm26;
  logic [31:0] D_jr_target, E_PC, E_target;
  logic [31:0] F_PC;
  logic        F_pred, flush_F;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  npc_bht dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .F_is_br     (F_is_br),
    .F_is_jal    (F_is_jal),
    .F_Imm26     (F_Imm26),
    .D_jr        (D_jr),
    .D_jr_target (D_jr_target),
    .E_br        (E_br),
    .E_PC        (E_PC),
    .E_taken     (E_taken),
    .E_pred      (E_pred),
    .E_target    (E_target),
    .F_PC        (F_PC),
    .F_pred      (F_pred),
    .flush_F     (flush_F)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; F_is_br = 0; F_is_jal = 0; F_Imm26 = '0; D_jr = 0; D_jr_target = '0;
    E_br = 0; E_PC = '0; E_taken = 0; E_pred = 0; E_target = '0;
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    D_jr = 1; D_jr_target = tgt;
    step();
    D_jr = 0;
  endtask

  initial begin
    bit exp_pred [8];
    bit tk       [8];
    exp_pred = '{1, 1, 1, 0, 0, 0, 0, 1};
    tk       = '{1, 1, 0, 0, 0, 0, 1, 1};

    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    #1;
    chk("reset_pc", F_PC, 32'h3000);
    chk("reset_flush", {31'd0, flush_F}, 32'd0);
    chk("reset_pred", {31'd0, F_pred}, 32'd0);
    step(); chk("seq_pc1", F_PC, 32'h3004);
    step(); chk("seq_pc2", F_PC, 32'h3008);
    chk("seq_flush", {31'd0, flush_F}, 32'd0);
    step(); step();
    chk("seq_pc4", F_PC, 32'h3010);

    // forward branch, counter WNT: predicted not-taken, then mispredict repair
    F_is_br = 1; F_Imm26 = 26'h0004; #1;
    chk("fwd_pred", {31'd0, F_pred}, 32'd0);
    step(); F_is_br = 0; F_Imm26 = '0;
    chk("br_slot", F_PC, 32'h3014);
    step();
    chk("br_fallthru", F_PC, 32'h3018);
    E_br = 1; E_taken = 1; E_pred = 0; E_PC = 32'h3010; E_target = 32'h3024; #1;
    chk("mis_flush", {31'd0, flush_F}, 32'd1);
    step(); E_br = 0;
    chk("mis_fix", F_PC, 32'h3024);
    #1; chk("mis_flush_drop", {31'd0, flush_F}, 32'd0);

    // counter walk at index of 0x3010, frozen PC under stall
    jump_to(32'h3010);
    chk("jr_pc", F_PC, 32'h3010);
    stall = 1; F_is_br = 1; F_Imm26 = 26'h0004; #1;
    chk("bht_wt", {31'd0, F_pred}, {31'd0, BHT_ON});
    for (int i = 0; i < 8; i++) begin
      E_br = 1; E_PC = 32'h3010; E_taken = tk[i]; E_pred = tk[i]; E_target = 32'h3024; #1;
      chk($sformatf("bht_noflush%0d", i), {31'd0, flush_F}, 32'd0);
      step();
      chk($sformatf("bht_step%0d", i), {31'd0, F_pred}, {31'd0, BHT_ON & exp_pred[i]});
    end
    E_br = 0;
    chk("stall_hold", F_PC, 32'h3010);
    stall = 0;

    // backward branch: predicted taken in both builds, target sign-extended
    F_Imm26 = 26'h0FFFC; #1;
    chk("bwd_pred", {31'd0, F_pred}, 32'd1);
    step(); F_is_br = 0; F_Imm26 = '0;
    chk("bwd_slot", F_PC, 32'h3014);
    step();
    chk("bwd_target", F_PC, 32'h3004);

    // fresh index, forward branch stays not-taken
    F_is_br = 1; F_Imm26 = 26'h0004; #1;
    chk("fwd_pred2", {31'd0, F_pred}, 32'd0);
    step(); F_is_br = 0; F_Imm26 = '0;
    chk("fwd_slot2", F_PC, 32'h3008);
    step();
    chk("fwd_fallthru2", F_PC, 32'h300C);

    // jal
    jump_to(32'h3020);
    F_is_jal = 1; F_Imm26 = 26'h0000C10; #1;
    chk("jal_noflush", {31'd0, flush_F}, 32'd0);
    step(); F_is_jal = 0; F_Imm26 = '0;
    chk("jal_slot", F_PC, 32'h3024);
    step();
    chk("jal_target", F_PC, 32'h3040);
    chk("jal_flush", {31'd0, flush_F}, 32'd0);

    // pending branch then mispredicts under stall; the later one wins
    F_is_br = 1; F_Imm26 = 26'h0004;
    step(); F_is_br = 0; F_Imm26 = '0;
    chk("pend_slot", F_PC, 32'h3044);
    stall = 1; E_br = 1; E_taken = 1; E_pred = 0; E_PC = 32'h3030; E_target = 32'h3200; #1;
    chk("stall_mis_flush", {31'd0, flush_F}, 32'd1);
    step();
    chk("stall_mis_hold", F_PC, 32'h3044);
    E_target = 32'h3100;
    step(); E_br = 0; #1;
    chk("stall_mis_hold2", F_PC, 32'h3044);
    chk("stall_idle_flush", {31'd0, flush_F}, 32'd0);
    step();
    stall = 0; #1;
    chk("release_flush", {31'd0, flush_F}, 32'd1);
    step();
    chk("redir_pc", F_PC, 32'h3100);
    chk("redir_flush_drop", {31'd0, flush_F}, 32'd0);
    step();
    chk("pend_discard", F_PC, 32'h3104);

    // mispredict beats jr in the same cycle
    D_jr = 1; D_jr_target = 32'h3200;
    E_br = 1; E_taken = 0; E_pred = 1; E_PC = 32'h3050; E_target = 32'h3300; #1;
    chk("mis_jr_flush", {31'd0, flush_F}, 32'd1);
    step(); idle_inputs();
    chk("mis_over_jr", F_PC, 32'h3058);
    step();
    chk("after_mis_jr", F_PC, 32'h305C);

    // reset restores PC and counters
    reset = 1;
    step();
    reset = 0; #1;
    chk("rereset_pc", F_PC, 32'h3000);
    jump_to(32'h3010);
    stall = 1; F_is_br = 1; F_Imm26 = 26'h0004; #1;
    chk("rereset_cnt", {31'd0, F_pred}, 32'd0);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
